// File: rtl/mux_arbiter_4bit.sv
// Round-robin arbiter plus one-entry output register for the shared 2:1 mux datapath.
// Define ARB_BURST_EN to let a tie winner keep priority for up to MAX_BURST beats.
module mux_arbiter_4bit #(
  parameter int WIDTH = 4
`ifdef ARB_BURST_EN
  ,
  parameter int MAX_BURST = 4
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  input  logic             y_ready,
  output logic             y_src,
  output logic             busy,
  output logic             dbg_state
);

  // Handshake: a word moves on any edge where valid && ready are both high.
  // a_ready/b_ready are the accept strobes; y_valid stays up until y_ready.

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic             last_grant;
  logic [WIDTH-1:0] y_data_q;
  logic             y_src_q;

  logic can_accept;
  logic tie_grant;
  logic grant;
  logic accept;

`ifdef ARB_BURST_EN
  localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);
  logic [3:0] burst_cnt;

  // A count of zero means no winner yet, so the tie falls back to ~last_grant.
  always_comb begin
    tie_grant = ~last_grant;
    if ((burst_cnt != 4'd0) && (burst_cnt < MAX_BURST_C)) tie_grant = last_grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt <= 4'd0;
    end else if (accept) begin
      if ((grant == last_grant) && (burst_cnt != 4'd0)) begin
        if (burst_cnt < MAX_BURST_C) burst_cnt <= burst_cnt + 4'd1;
      end else begin
        burst_cnt <= 4'd1;
      end
    end
  end
`else
  assign tie_grant = ~last_grant;
`endif

  assign can_accept = (state_q == EMPTY) || y_ready;

  always_comb begin
    grant = 1'b0;
    if (a_valid && b_valid) grant = tie_grant;
    else if (b_valid)       grant = 1'b1;
  end

  // Readies are forced low while reset is asserted so no word is taken then.
  assign a_ready = reset_n & can_accept & a_valid & ~grant;
  assign b_ready = reset_n & can_accept & b_valid &  grant;
  assign accept  = a_ready | b_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      last_grant <= 1'b1;
      y_data_q   <= '0;
      y_src_q    <= 1'b0;
    end else if (accept) begin
      y_data_q   <= grant ? b_data : a_data;
      y_src_q    <= grant;
      last_grant <= grant;
      state_q    <= FULL;
    end else if ((state_q == FULL) && y_ready) begin
      state_q <= EMPTY;
    end
  end

  assign y_valid   = (state_q == FULL);
  assign y_data    = y_data_q;
  assign y_src     = y_src_q;
  assign busy      = y_valid | a_valid | b_valid;
  assign dbg_state = state_q;

endmodule
